// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core memory stage (master) and the responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_lane_align.sv
// RV32I lane steering: byte enables, shifted store data, extended load data, error flag.
// Purely combinational; an erroring or load access never produces byte enables.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic        we,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_sh,
   output logic [31:0] ldata,
   output logic        err
);
   logic [31:0] rsh;
   logic [3:0]  be_raw;
   logic [31:0] ld_raw;

   assign rsh      = rword >> {addr_lo, 3'b000};
   assign wdata_sh = wdata << {addr_lo, 3'b000};

   always_comb begin
      be_raw = 4'b0000;
      ld_raw = 32'h0;
      err    = 1'b0;
      case (funct3)
         F3_B: begin
            be_raw = 4'b0001 << addr_lo;
            ld_raw = {{24{rsh[7]}}, rsh[7:0]};
         end
         F3_BU: begin
            err    = we;
            ld_raw = {24'h0, rsh[7:0]};
         end
         F3_H: begin
            err    = addr_lo[0];
            be_raw = 4'b0011 << {addr_lo[1], 1'b0};
            ld_raw = {{16{rsh[15]}}, rsh[15:0]};
         end
         F3_HU: begin
            err    = addr_lo[0] | we;
            ld_raw = {16'h0, rsh[15:0]};
         end
         F3_W: begin
            err    = (addr_lo != 2'b00);
            be_raw = 4'b1111;
            ld_raw = rword;
         end
         default: err = 1'b1;
      endcase
   end

   assign be    = (err || !we) ? 4'b0000 : be_raw;
   assign ldata = err ? 32'h0 : ld_raw;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_CYCLES wait states, one-cycle response pulse.
// Response arrives WAIT_CYCLES+1 cycles after accept; no response backpressure.
// DMEM_BACK2BACK_EN: also accept a new request during RESP.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input logic clk,
   input logic reset,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [CNT_W-1:0] CNT_INIT = ZERO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);
`ifdef DMEM_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [AW+1:0]     addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [2:0]        f3_q;
   logic [31:0]       mem [0:DEPTH_WORDS-1];

   logic              accept, go_resp;
   logic [AW+1:0]     op_addr;
   logic              op_we;
   logic [31:0]       op_wdata;
   logic [2:0]        op_f3;
   logic [AW-1:0]     op_idx;
   logic [31:0]       rword, wdata_sh, ldata;
   logic [3:0]        be;
   logic              err;
   logic              unused_addr;

   assign unused_addr   = ^bus.req_addr[31:AW+2];
   assign bus.req_ready = (state == ST_IDLE) || (B2B && state == ST_RESP);
   assign bus.rsp_valid = (state == ST_RESP);
   assign accept        = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ZERO_WAIT ? ST_RESP : ST_WAIT;
         ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
         ST_RESP: state_nxt = accept ? (ZERO_WAIT ? ST_RESP : ST_WAIT) : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // With no wait states the access completes on the accept edge, so it uses the live request.
   assign go_resp  = !reset && (state_nxt == ST_RESP);
   assign op_addr  = ZERO_WAIT ? bus.req_addr[AW+1:0] : addr_q;
   assign op_we    = ZERO_WAIT ? bus.req_we           : we_q;
   assign op_wdata = ZERO_WAIT ? bus.req_wdata        : wdata_q;
   assign op_f3    = ZERO_WAIT ? bus.req_funct3       : f3_q;
   assign op_idx   = op_addr[AW+1:2];
   assign rword    = mem[op_idx];

   dmem_lane_align u_align (
      .addr_lo  (op_addr[1:0]),
      .funct3   (op_f3),
      .we       (op_we),
      .wdata    (op_wdata),
      .rword    (rword),
      .be       (be),
      .wdata_sh (wdata_sh),
      .ldata    (ldata),
      .err      (err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt           <= '0;
         addr_q        <= '0;
         we_q          <= 1'b0;
         wdata_q       <= 32'h0;
         f3_q          <= 3'b000;
         bus.rsp_rdata <= 32'h0;
         bus.rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            cnt     <= CNT_INIT;
            addr_q  <= bus.req_addr[AW+1:0];
            we_q    <= bus.req_we;
            wdata_q <= bus.req_wdata;
            f3_q    <= bus.req_funct3;
         end else if (state == ST_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (go_resp) begin
            bus.rsp_rdata <= op_we ? 32'h0 : ldata;
            bus.rsp_err   <= err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (go_resp) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[op_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a WAIT_CYCLES=2 responder and a WAIT_CYCLES=0 responder share request fields.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

`ifdef DMEM_BACK2BACK_EN
   localparam bit B2B = 1'b1;
`else
   localparam bit B2B = 1'b0;
`endif

   dmem_responder_if bus();
   dmem_responder_if bus0();

   logic        t_vld, t_sel, t_we;
   logic [31:0] t_addr, t_wdata;
   logic [2:0]  t_f3;

   assign bus.req_valid   = t_vld && !t_sel;
   assign bus0.req_valid  = t_vld && t_sel;
   assign bus.req_we      = t_we;
   assign bus0.req_we     = t_we;
   assign bus.req_addr    = t_addr;
   assign bus0.req_addr   = t_addr;
   assign bus.req_wdata   = t_wdata;
   assign bus0.req_wdata  = t_wdata;
   assign bus.req_funct3  = t_f3;
   assign bus0.req_funct3 = t_f3;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

   int checks = 0;
   int errors = 0;

   int          r_lat;
   logic [31:0] r_rdata;
   logic        r_err, r_busy, r_rdy, r_pulse;

   function automatic logic cur_rdy();
      return t_sel ? bus0.req_ready : bus.req_ready;
   endfunction
   function automatic logic cur_vld();
      return t_sel ? bus0.rsp_valid : bus.rsp_valid;
   endfunction
   function automatic logic [31:0] cur_rdata();
      return t_sel ? bus0.rsp_rdata : bus.rsp_rdata;
   endfunction
   function automatic logic cur_err();
      return t_sel ? bus0.rsp_err : bus.rsp_err;
   endfunction

   // One request on the selected DUT; starts and ends 1ns after a rising edge.
   task automatic do_req(input logic sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
      int budget;
      r_lat = 99; r_rdata = 32'h0; r_err = 1'b0; r_busy = 1'b1; r_rdy = 1'b0; r_pulse = 1'b0;
      t_sel = sel; t_we = we; t_addr = addr; t_wdata = wdata; t_f3 = f3; t_vld = 1'b1;
      budget = 0;
      while (!cur_rdy() && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      @(posedge clk); #1;
      t_vld = 1'b0; t_we = ~we; t_addr = ~addr; t_wdata = ~wdata; t_f3 = 3'b111;
      for (int c = 1; c <= 20; c++) begin
         if (cur_vld()) begin
            r_lat = c; r_rdata = cur_rdata(); r_err = cur_err(); r_rdy = cur_rdy();
            break;
         end
         if (cur_rdy()) r_busy = 1'b0;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      r_pulse = !cur_vld();
   endtask

   task automatic test_reset();
      reset = 1'b1; t_vld = 1'b0; t_sel = 1'b0; t_we = 1'b0;
      t_addr = 32'h0; t_wdata = 32'h0; t_f3 = F3_W;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.rsp_valid); end
      checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rsp_rdata); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.rsp_err); end
      checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready0 got %b exp 1", bus0.req_ready); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_word();
      do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W);
      checks++; if (r_lat !== 3) begin errors++; $display("FAIL sw_lat got %0d exp 3", r_lat); end
      checks++; if (r_rdata !== 32'h0 || r_err !== 1'b0) begin errors++; $display("FAIL sw_rsp got %h/%b exp 0/0", r_rdata, r_err); end
      checks++; if (r_busy !== 1'b1) begin errors++; $display("FAIL wait_ready got ready-in-wait exp none"); end
      checks++; if (r_pulse !== 1'b1) begin errors++; $display("FAIL pulse_width got >1 cycle exp 1"); end
      checks++; if (r_rdy !== B2B) begin errors++; $display("FAIL resp_ready got %b exp %b", r_rdy, B2B); end
      do_req(1'b0, 1'b0, 32'h10, 32'h0, F3_W);
      checks++; if (r_lat !== 3) begin errors++; $display("FAIL lw_lat got %0d exp 3", r_lat); end
      checks++; if (r_rdata !== 32'hDEADBEEF || r_err !== 1'b0) begin errors++; $display("FAIL lw got %h/%b exp deadbeef/0", r_rdata, r_err); end
   endtask

   task automatic test_subword();
      do_req(1'b0, 1'b1, 32'h11, 32'h00000080, F3_B);
      checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL sb_err got %b exp 0", r_err); end
      do_req(1'b0, 1'b0, 32'h11, 32'h0, F3_B);
      checks++; if (r_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h exp ffffff80", r_rdata); end
      do_req(1'b0, 1'b0, 32'h11, 32'h0, F3_BU);
      checks++; if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu got %h exp 00000080", r_rdata); end
      do_req(1'b0, 1'b0, 32'h10, 32'h0, F3_W);
      checks++; if (r_rdata !== 32'hDEAD80EF) begin errors++; $display("FAIL lw_after_sb got %h exp dead80ef", r_rdata); end
      do_req(1'b0, 1'b0, 32'h12, 32'h0, F3_H);
      checks++; if (r_rdata !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh got %h exp ffffdead", r_rdata); end
      do_req(1'b0, 1'b0, 32'h10, 32'h0, F3_HU);
      checks++; if (r_rdata !== 32'h000080EF) begin errors++; $display("FAIL lhu got %h exp 000080ef", r_rdata); end
      do_req(1'b0, 1'b1, 32'h14, 32'h00000000, F3_W);
      do_req(1'b0, 1'b1, 32'h16, 32'h5678ABCD, F3_H);
      do_req(1'b0, 1'b0, 32'h14, 32'h0, F3_W);
      checks++; if (r_rdata !== 32'hABCD0000) begin errors++; $display("FAIL sh_lw got %h exp abcd0000", r_rdata); end
   endtask

   task automatic test_errors();
      do_req(1'b0, 1'b1, 32'h13, 32'h0000FFFF, F3_H);
      checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL sh_misal got %b/%h exp 1/0", r_err, r_rdata); end
      do_req(1'b0, 1'b0, 32'h12, 32'h0, F3_W);
      checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL lw_misal got %b/%h exp 1/0", r_err, r_rdata); end
      do_req(1'b0, 1'b0, 32'h10, 32'h0, 3'b011);
      checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL ld_f3_011 got %b/%h exp 1/0", r_err, r_rdata); end
      do_req(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, F3_BU);
      checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL st_f3_bu got %b exp 1", r_err); end
      do_req(1'b0, 1'b0, 32'h10, 32'h0, F3_W);
      checks++; if (r_rdata !== 32'hDEAD80EF || r_err !== 1'b0) begin errors++; $display("FAIL err_nowrite got %h/%b exp dead80ef/0", r_rdata, r_err); end
   endtask

   task automatic test_wrap();
      do_req(1'b0, 1'b1, 32'h100, 32'h12345678, F3_W);
      do_req(1'b0, 1'b0, 32'h0, 32'h0, F3_W);
      checks++; if (r_rdata !== 32'h12345678) begin errors++; $display("FAIL wrap got %h exp 12345678", r_rdata); end
      do_req(1'b0, 1'b0, 32'h80000000, 32'h0, F3_W);
      checks++; if (r_rdata !== 32'h12345678) begin errors++; $display("FAIL wrap_hi got %h exp 12345678", r_rdata); end
   endtask

   task automatic test_reset_midop();
      logic seen;
      seen = 1'b0;
      t_sel = 1'b0; t_we = 1'b1; t_addr = 32'h10; t_wdata = 32'h0; t_f3 = F3_W; t_vld = 1'b1;
      @(posedge clk); #1;
      t_vld = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1 seen = bus.rsp_valid;
      repeat (3) begin @(posedge clk); #1; seen |= bus.rsp_valid; end
      reset = 1'b0;
      repeat (4) begin @(posedge clk); #1; seen |= bus.rsp_valid; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_drop got rsp_valid exp none"); end
      do_req(1'b0, 1'b0, 32'h10, 32'h0, F3_W);
      checks++; if (r_rdata !== 32'hDEAD80EF) begin errors++; $display("FAIL reset_nowrite got %h exp dead80ef", r_rdata); end
   endtask

   task automatic test_zero_wait();
      do_req(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, F3_W);
      checks++; if (r_lat !== 1) begin errors++; $display("FAIL zw_sw_lat got %0d exp 1", r_lat); end
      do_req(1'b1, 1'b0, 32'h20, 32'h0, F3_W);
      checks++; if (r_lat !== 1 || r_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL zw_lw got %0d/%h exp 1/a5a5a5a5", r_lat, r_rdata); end
      checks++; if (r_pulse !== 1'b1) begin errors++; $display("FAIL zw_pulse got >1 cycle exp 1"); end
      do_req(1'b1, 1'b0, 32'h22, 32'h0, F3_H);
      checks++; if (r_rdata !== 32'hFFFFA5A5 || r_err !== 1'b0) begin errors++; $display("FAIL zw_lh got %h/%b exp ffffa5a5/0", r_rdata, r_err); end
   endtask

   // Request held valid: a store then a load to the same word; measures response spacing.
   task automatic test_back_to_back(input logic sel, input int wait_cycles, input logic [31:0] addr);
      int n_acc, n_rsp, t1, gap;
      logic go, rdy_all;
      logic [31:0] ld;
      logic ld_err;
      n_acc = 0; n_rsp = 0; t1 = 0; gap = 99; rdy_all = 1'b1; ld = 32'h0; ld_err = 1'b1;
      t_sel = sel; t_we = 1'b1; t_addr = addr; t_wdata = 32'h5A5A5A5A; t_f3 = F3_W; t_vld = 1'b1;
      for (int c = 0; c < 30 && n_rsp < 2; c++) begin
         go = t_vld && cur_rdy();
         rdy_all &= cur_rdy();
         @(posedge clk); #1;
         if (go) begin
            n_acc++;
            if (n_acc == 1) begin t_we = 1'b0; t_wdata = 32'h0; end
            else t_vld = 1'b0;
         end
         if (cur_vld()) begin
            n_rsp++;
            if (n_rsp == 1) t1 = c;
            else begin gap = c - t1; ld = cur_rdata(); ld_err = cur_err(); end
         end
      end
      t_vld = 1'b0;
      @(posedge clk); #1;
      checks++; if (gap !== wait_cycles + (B2B ? 1 : 2)) begin errors++; $display("FAIL b2b_gap%0d got %0d exp %0d", wait_cycles, gap, wait_cycles + (B2B ? 1 : 2)); end
      checks++; if (ld !== 32'h5A5A5A5A || ld_err !== 1'b0) begin errors++; $display("FAIL b2b_load%0d got %h/%b exp 5a5a5a5a/0", wait_cycles, ld, ld_err); end
      checks++; if (rdy_all !== (B2B && wait_cycles == 0)) begin errors++; $display("FAIL b2b_ready%0d got %b exp %b", wait_cycles, rdy_all, (B2B && wait_cycles == 0)); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword();
      test_errors();
      test_wrap();
      test_reset_midop();
      test_zero_wait();
      test_back_to_back(1'b1, 0, 32'h28);
      test_back_to_back(1'b0, 2, 32'h2C);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RISC-V core. It serves load/store requests issued from the core's memory stage.
- Uses a valid/ready request handshake, configurable wait states and a one-cycle response pulse.
- Performs RV32I byte/halfword/word lane steering, load sign/zero extension and misalignment detection.
- Replaces the zero-latency data memory when the core is built with memory stall support.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words in the internal array; power of two.
- WAIT_CYCLES, 2: extra cycles between request accept and response; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address (ALU result)
- req_wdata  input  32  store data, right-aligned (rs2)
- req_funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  load result, already extended; 0 for stores and errors
- rsp_err  output  1  misaligned or illegal funct3; qualified by rsp_valid

Behaviour:
- States:
  - IDLE: req_ready = 1.
  - WAIT: count down.
  - RESP: rsp_valid = 1.
- Transitions:
  - IDLE to WAIT on req_valid && req_ready when WAIT_CYCLES > 0.
  - IDLE to RESP on req_valid && req_ready when WAIT_CYCLES = 0.
  - WAIT to RESP when the counter reaches 0.
  - RESP to IDLE unconditionally.
- Request capture: addr, we, wdata and funct3 are registered on the accept edge. Later input changes are ignored.
- Latency: a request accepted at edge T asserts rsp_valid during cycle T+WAIT_CYCLES+1, for exactly one cycle. There is no response backpressure.
- Wait counter: loaded with WAIT_CYCLES-1 on accept, decrements each cycle in WAIT.
- Word index: addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so the address space wraps modulo DEPTH_WORDS*4.
- Store commit: the array write happens on the edge entering RESP, using byte enables:
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
- Load data: registered on the edge entering RESP, from the current array contents.
  - LB/LH are sign-extended; LBU/LHU are zero-extended; LW is passed through.
- Errors: halfword access with addr[0] = 1, word access with addr[1:0] != 0, store funct3 not in {000,001,010}, or load funct3 in {011,110,111}. On error:
  - rsp_err = 1, rsp_rdata = 0, and no array write.
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0. Array contents are not reset.
- Reset mid-operation: a pending request is discarded, no write occurs and no response is produced.
- req_valid arriving while not ready: ignored. The requester must hold it until a handshake occurs.

Optional Feature:
- Macro: DMEM_BACK2BACK_EN.
- Defined: req_ready is also 1 in RESP. A handshake in RESP captures the new request and moves directly to WAIT, or to RESP if WAIT_CYCLES = 0. Sustained throughput is one access per WAIT_CYCLES+1 cycles. A store committed in the prior RESP is visible to the new load.
- Undefined: req_ready is 1 only in IDLE. Minimum request spacing is WAIT_CYCLES+2 cycles.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum: ST_IDLE, ST_WAIT, ST_RESP.
  - WAIT counter width constant (4).
- Sub-module dmem_lane_align: combinational logic that, from addr[1:0], funct3, wdata and the raw read word, produces the 4-bit byte enable, shifted write data, extended load data and the error flag. This keeps the FSM module sequential-only.

Test Plan:
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10 (WAIT_CYCLES=2) -> rsp_valid 3 cycles after each accept; load returns rdata = 0xDEADBEEF, err = 0.
- After the above, SB 0x80 @0x11, then LB @0x11 -> 0xFFFFFF80; LBU @0x11 -> 0x00000080; LW @0x10 -> 0xDEAD80EF.
- SH @0x13 and LW @0x12 -> rsp_err = 1, rdata = 0; a subsequent LW @0x10 still returns 0xDEAD80EF (no write occurred).
- With DEPTH_WORDS=64, SW 0x12345678 @0x100 then LW @0x0 -> 0x12345678 (address wrap).
- Assert reset one cycle after accepting SW 0x0 @0x10 -> no rsp_valid; LW @0x10 after reset returns 0xDEAD80EF.
- DMEM_BACK2BACK_EN, WAIT_CYCLES=0 -> req_ready held at 1; SW 0xA5A5A5A5 @0x20 followed immediately by LW @0x20 -> responses on consecutive cycles, load returns 0xA5A5A5A5.
